// File: rtl/tdm_demux_rx_if.sv
// Output word channel of the TDM receiver: received word with a valid/ready handshake.
interface tdm_demux_rx_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] data_out;
  logic             data_vld;
  logic             data_rdy;

  modport master (output data_out, output data_vld, input data_rdy);
  modport slave  (input data_out, input data_vld, output data_rdy);
endinterface

// File: rtl/tdm_demux_rx.sv
// TDM link receiver: re-assembles LSB-first serial beats into WIDTH-bit words.
// Optional even-parity beat per frame enabled by defining TDM_RX_PARITY_EN.
module tdm_demux_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           serial_in,
  input  logic           serial_vld,
  input  logic           frame_start,
  tdm_demux_rx_if.master out_if,
  output logic           busy,
  output logic           frame_err,
  output logic           overrun,
  input  logic           clr_overrun,
  output logic           parity_err
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef TDM_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_e;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_vld_q, data_vld_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             parity_err_q, parity_err_d;
  logic             commit;
  logic [WIDTH-1:0] commit_word;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_vld_d   = data_vld_q;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;
    parity_err_d = 1'b0;
    commit       = 1'b0;
    commit_word  = shift_q;

    unique case (state_q)
      IDLE: begin
        if (serial_vld && frame_start) begin
          shift_d    = '0;
          shift_d[0] = serial_in;
          cnt_d      = CNT_ONE;
          state_d    = RECV;
        end
      end
      RECV: begin
        if (serial_vld && frame_start) begin
          frame_err_d = 1'b1;
          shift_d     = '0;
          shift_d[0]  = serial_in;
          cnt_d       = CNT_ONE;
        end else if (serial_vld) begin
          shift_d[cnt_q] = serial_in;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef TDM_RX_PARITY_EN
            state_d = PAR;
`else
            state_d     = IDLE;
            commit      = 1'b1;
            commit_word = shift_d;
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
`ifdef TDM_RX_PARITY_EN
      PAR: begin
        if (serial_vld && frame_start) begin
          frame_err_d = 1'b1;
          shift_d     = '0;
          shift_d[0]  = serial_in;
          cnt_d       = CNT_ONE;
          state_d     = RECV;
        end else if (serial_vld) begin
          state_d = IDLE;
          if (^{shift_q, serial_in} == 1'b0) begin
            commit      = 1'b1;
            commit_word = shift_q;
          end else begin
            parity_err_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A commit in the same cycle as a consumer handshake refills the register.
    if (data_vld_q && out_if.data_rdy) data_vld_d = 1'b0;
    if (clr_overrun) overrun_d = 1'b0;
    if (commit) begin
      if (!data_vld_q || out_if.data_rdy) begin
        data_out_d = commit_word;
        data_vld_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_vld_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_vld_q   <= data_vld_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign out_if.data_out = data_out_q;
  assign out_if.data_vld = data_vld_q;
  assign busy            = (state_q != IDLE);
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;
`ifdef TDM_RX_PARITY_EN
  assign parity_err      = parity_err_q;
`else
  assign parity_err      = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Scoreboard bench for tdm_demux_rx: expected words queued at stimulus time,
// popped and compared by a monitor on every output transfer.
module tb_tdm_demux_rx;
  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic reset, serial_in, serial_vld, frame_start, clr_overrun;
  logic busy, frame_err, overrun, parity_err;

  tdm_demux_rx_if #(.WIDTH(WIDTH)) out_if ();

  tdm_demux_rx #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .serial_vld  (serial_vld),
    .frame_start (frame_start),
    .out_if      (out_if.master),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fe_count = 0;
  int pe_count = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: a transfer is taken on the edge following a cycle with vld&rdy.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err === 1'b1) fe_count++;
      if (parity_err === 1'b1) pe_count++;
      if (out_if.data_vld === 1'b1 && out_if.data_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {28'd0, out_if.data_out}, 32'hDEAD);
        end else begin
          check("word", {28'd0, out_if.data_out}, {28'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic beat(input logic b, input logic fs);
    serial_in   = b;
    serial_vld  = 1'b1;
    frame_start = fs;
    @(posedge clk); #1;
    serial_vld  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input bit expect_out);
    if (expect_out) exp_q.push_back(w);
    for (int i = 0; i < int'(WIDTH); i++) beat(w[i], i == 0);
`ifdef TDM_RX_PARITY_EN
    beat(^w, 1'b0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    reset = 1'b0; serial_in = 1'b0; serial_vld = 1'b0; frame_start = 1'b0;
    clr_overrun = 1'b0; out_if.data_rdy = 1'b1;
    #12;
    check("rst_vld",  {31'd0, out_if.data_vld}, 32'd0);
    check("rst_data", {28'd0, out_if.data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovr",  {31'd0, overrun}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Beat without frame_start in IDLE is dropped.
    beat(1'b1, 1'b0);
    check("idle_discard_busy", {31'd0, busy}, 32'd0);

    // T1: reset mid-frame, then a clean frame.
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    check("t1_busy_mid", {31'd0, busy}, 32'd1);
    reset = 1'b0; #2;
    check("t1_busy_rst", {31'd0, busy}, 32'd0);
    check("t1_vld_rst",  {31'd0, out_if.data_vld}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    send_frame(4'h6, 1'b1);
    idle(2);

    // T2: 1,0,0,1 LSB first -> 4'b1001, valid one clock after last beat.
    exp_q.push_back(4'b1001);
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
`ifdef TDM_RX_PARITY_EN
    beat(1'b0, 1'b0);
`endif
    check("t2_vld_latency", {31'd0, out_if.data_vld}, 32'd1);
    check("t2_data",        {28'd0, out_if.data_out}, 32'h9);
    check("t2_busy_done",   {31'd0, busy}, 32'd0);
    idle(2);
    check("t2_vld_fall",    {31'd0, out_if.data_vld}, 32'd0);

    // T3: second word dropped while output full.
    out_if.data_rdy = 1'b0;
    send_frame(4'hA, 1'b1);
    send_frame(4'h5, 1'b0);
    check("t3_overrun", {31'd0, overrun}, 32'd1);
    check("t3_data",    {28'd0, out_if.data_out}, 32'hA);
    clr_overrun = 1'b1;
    @(posedge clk); #1 clr_overrun = 1'b0;
    check("t3_clr", {31'd0, overrun}, 32'd0);
    out_if.data_rdy = 1'b1;
    idle(2);

    // T4: idle gaps between beats.
    exp_q.push_back(4'h3);
    beat(1'b1, 1'b1); idle(3);
    beat(1'b1, 1'b0); idle(3);
    check("t4_busy_gap", {31'd0, busy}, 32'd1);
    beat(1'b0, 1'b0); idle(3);
    beat(1'b0, 1'b0);
`ifdef TDM_RX_PARITY_EN
    idle(3);
    beat(1'b0, 1'b0);
`endif
    idle(2);

    // T5: restart mid-frame.
    fe0 = fe_count;
    beat(1'b1, 1'b1); beat(1'b1, 1'b0);
    send_frame(4'hC, 1'b1);
    idle(3);
    check("t5_frame_err_pulses", fe_count - fe0, 32'd1);

`ifdef TDM_RX_PARITY_EN
    // T6: good parity commits, bad parity is dropped with a pulse.
    begin
      int pe0;
      logic [WIDTH-1:0] w7;
      w7 = 4'h7;
      send_frame(w7, 1'b1);
      idle(3);
      pe0 = pe_count;
      for (int i = 0; i < int'(WIDTH); i++) beat(w7[i], i == 0);
      beat(1'b0, 1'b0);
      idle(2);
      check("t6_parity_err", pe_count - pe0, 32'd1);
      check("t6_vld_low",    {31'd0, out_if.data_vld}, 32'd0);
      check("t6_no_overrun", {31'd0, overrun}, 32'd0);
    end
`else
    check("parity_err_tied", {31'd0, parity_err}, 32'd0);
`endif

    idle(4);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
